// File: rtl/extender_pipe.sv
// Immediate extender with a 2-entry skid buffer on the result path.
// Results are computed on acceptance and stored; the head entry drives Out/Err directly.
module extender_pipe #(
   parameter int unsigned IN_WIDTH  = 16,
   parameter int unsigned OUT_WIDTH = 32
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 InValid,
   output logic                 InReady,
   input  logic [2:0]           Mode,
   input  logic [IN_WIDTH-1:0]  In,
   output logic                 OutValid,
   input  logic                 OutReady,
   output logic [OUT_WIDTH-1:0] Out,
   output logic                 Err
);

   localparam int unsigned PadWidth = OUT_WIDTH - IN_WIDTH;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t               state;
   logic [OUT_WIDTH-1:0] tailData;
   logic                 tailErr;
   logic [OUT_WIDTH-1:0] extData;
   logic                 extErr;
   logic [OUT_WIDTH-1:0] signExt;
   logic                 push;
   logic                 pop;

   assign push = InValid & InReady;
   assign pop  = OutValid & OutReady;

   // Extension of the currently offered immediate.
   always_comb begin
      signExt = OUT_WIDTH'($signed(In));
      extData = '0;
      extErr  = 1'b0;
      case (Mode)
         3'd0:    extData = OUT_WIDTH'(In);
         3'd1:    extData = signExt;
         3'd2:    extData = {In, {PadWidth{1'b0}}};
         3'd3:    extData = signExt << 2;
         3'd4:    extData = OUT_WIDTH'($signed(In[7:0]));
         3'd5:    extData = OUT_WIDTH'(In[7:0]);
         default: extErr  = 1'b1;
      endcase
   end

   // Head entry lives in Out/Err; the tail only fills while the head is stalled.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= EMPTY;
         InReady  <= 1'b1;
         OutValid <= 1'b0;
         Out      <= '0;
         Err      <= 1'b0;
         tailData <= '0;
         tailErr  <= 1'b0;
      end else begin
         case (state)
            EMPTY: begin
               if (push) begin
                  Out      <= extData;
                  Err      <= extErr;
                  OutValid <= 1'b1;
                  state    <= ONE;
               end
            end
            ONE: begin
               if (push && pop) begin
                  Out <= extData;
                  Err <= extErr;
               end else if (push) begin
                  tailData <= extData;
                  tailErr  <= extErr;
                  InReady  <= 1'b0;
                  state    <= TWO;
               end else if (pop) begin
                  OutValid <= 1'b0;
                  state    <= EMPTY;
               end
            end
            TWO: begin
               if (pop) begin
                  Out     <= tailData;
                  Err     <= tailErr;
                  InReady <= 1'b1;
                  state   <= ONE;
               end
            end
            default: begin
               state    <= EMPTY;
               InReady  <= 1'b1;
               OutValid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_extender_pipe.sv
// Scoreboard bench for extender_pipe: arithmetic reference model, queue of expected
// results filled on acceptance and drained by an independent output monitor.
module tb_extender_pipe;

   logic        clock;
   logic        reset;
   logic        InValid;
   logic        InReady;
   logic [2:0]  Mode;
   logic [15:0] In;
   logic        OutValid;
   logic        OutReady;
   logic [31:0] Out;
   logic        Err;

   extender_pipe #(.IN_WIDTH(16), .OUT_WIDTH(32)) dut (
      .clock(clock), .reset(reset), .InValid(InValid), .InReady(InReady),
      .Mode(Mode), .In(In), .OutValid(OutValid), .OutReady(OutReady),
      .Out(Out), .Err(Err)
   );

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          cyc;
      bit          strict;
   } exp_t;

   exp_t        sbQ[$];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   bit          strictMode = 0;
   int          occ = 0;
   bit          stallHold = 0;
   logic [31:0] heldOut;
   logic        heldErr;

   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: interpret the immediate as a number and apply each mode's rule modulo 2^32.
   function automatic exp_t model(input logic [2:0] m, input logic [15:0] x);
      exp_t   e;
      longint sx;
      longint bv;
      longint r;
      sx = (x >= 16'h8000) ? longint'(x) - 65536 : longint'(x);
      bv = longint'(x) % 256;
      if (bv >= 128) bv = bv - 256;
      e.err = 1'b0;
      case (m)
         3'd0: r = longint'(x);
         3'd1: r = sx;
         3'd2: r = longint'(x) * 65536;
         3'd3: r = sx * 4;
         3'd4: r = bv;
         3'd5: r = longint'(x) % 256;
         default: begin r = 0; e.err = 1'b1; end
      endcase
      e.data = 32'(r);
      e.cyc = 0;
      e.strict = 0;
      return e;
   endfunction

   // Drive-side: record acceptance at the negative edge, then move past the next rising edge.
   task automatic step(output bit acc);
      exp_t e;
      @(negedge clock);
      acc = InValid && InReady && !reset;
      if (acc) begin
         e = model(Mode, In);
         e.cyc = cyc;
         e.strict = strictMode;
         sbQ.push_back(e);
      end
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      bit a;
      InValid = 1'b0;
      for (int i = 0; i < n; i++) step(a);
   endtask

   // Output monitor: protocol model plus scoreboard pop.
   always @(negedge clock) begin
      exp_t e;
      int   pushN;
      int   popN;
      if (reset) begin
         sbQ.delete();
         occ = 0;
         stallHold = 0;
      end else begin
         chk("in_ready", 64'(InReady), 64'(occ < 2));
         chk("out_valid", 64'(OutValid), 64'(occ > 0));
         if (OutValid && stallHold) begin
            chk("stall_out", 64'(Out), 64'(heldOut));
            chk("stall_err", 64'(Err), 64'(heldErr));
         end
         pushN = (InValid && InReady) ? 1 : 0;
         popN  = (OutValid && OutReady) ? 1 : 0;
         if (OutValid && OutReady) begin
            stallHold = 0;
            if (sbQ.size() == 0) begin
               chk("unexpected_out", 64'(Out), 64'hDEAD);
            end else begin
               e = sbQ.pop_front();
               chk("out_data", 64'(Out), 64'(e.data));
               chk("out_err", 64'(Err), 64'(e.err));
               if (e.strict) chk("latency", 64'(cyc), 64'(e.cyc + 1));
            end
         end else if (OutValid) begin
            stallHold = 1;
            heldOut = Out;
            heldErr = Err;
         end else begin
            stallHold = 0;
         end
         occ = occ + pushN - popN;
      end
   end

   initial begin : stim
      bit          acc;
      bit          got;
      logic [2:0]  sm[6];
      logic [15:0] sv[6];
      sm = '{3'd1, 3'd0, 3'd2, 3'd3, 3'd4, 3'd5};
      sv = '{16'h8001, 16'h8001, 16'h1234, 16'hFFFF, 16'h0080, 16'h0080};

      reset = 1'b1; InValid = 1'b0; OutReady = 1'b0; Mode = '0; In = '0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      chk("rst_out_valid", 64'(OutValid), 64'd0);
      chk("rst_in_ready", 64'(InReady), 64'd1);
      chk("rst_out", 64'(Out), 64'd0);
      chk("rst_err", 64'(Err), 64'd0);

      // Back-to-back streaming, each result one cycle after acceptance.
      OutReady = 1'b1;
      strictMode = 1;
      for (int i = 0; i < 6; i++) begin
         InValid = 1'b1; Mode = sm[i]; In = sv[i];
         step(acc);
         chk("stream_accept", 64'(acc), 64'd1);
      end
      idle(3);

      // Backpressure: A and B fill the buffer, C is held off.
      strictMode = 0;
      OutReady = 1'b0;
      InValid = 1'b1; Mode = 3'd0; In = 16'h000A;
      step(acc); chk("bp_accept_a", 64'(acc), 64'd1);
      Mode = 3'd1; In = 16'hB00B;
      step(acc); chk("bp_accept_b", 64'(acc), 64'd1);
      chk("bp_in_ready_low", 64'(InReady), 64'd0);
      Mode = 3'd4; In = 16'h00CC;
      for (int i = 0; i < 3; i++) begin
         step(acc); chk("bp_hold_c", 64'(acc), 64'd0);
      end
      OutReady = 1'b1;
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
         step(acc);
         got = acc;
      end
      chk("bp_c_accepted", 64'(got), 64'd1);
      idle(4);
      chk("bp_drained", 64'(sbQ.size()), 64'd0);

      // Reserved mode followed by a normal one.
      strictMode = 1;
      InValid = 1'b1; Mode = 3'd6; In = 16'hABCD;
      step(acc);
      Mode = 3'd1; In = 16'h0123;
      step(acc);
      Mode = 3'd7; In = 16'hFFFF;
      step(acc);
      idle(3);

      // Random traffic with random backpressure.
      strictMode = 0;
      for (int i = 0; i < 400; i++) begin
         InValid  = ($urandom_range(0, 3) != 0);
         Mode     = 3'($urandom_range(0, 7));
         In       = 16'($urandom);
         OutReady = ($urandom_range(0, 2) != 0);
         step(acc);
      end
      OutReady = 1'b1;
      idle(5);
      chk("rand_drained", 64'(sbQ.size()), 64'd0);

      // Reset while full, with handshakes active in the same cycle.
      OutReady = 1'b0;
      InValid = 1'b1; Mode = 3'd5; In = 16'h1111;
      step(acc);
      In = 16'h2222;
      step(acc);
      chk("full_before_reset", 64'(InReady), 64'd0);
      reset = 1'b1; OutReady = 1'b1; In = 16'h3333;
      step(acc);
      reset = 1'b0;
      InValid = 1'b0;
      chk("rst2_out_valid", 64'(OutValid), 64'd0);
      chk("rst2_in_ready", 64'(InReady), 64'd1);
      chk("rst2_out", 64'(Out), 64'd0);
      chk("rst2_err", 64'(Err), 64'd0);
      idle(4);
      chk("rst2_queue_empty", 64'(sbQ.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule

// File: doc/extender_pipe.md
EXTENDER_PIPE -- requirements
Module: extender_pipe

Interface
REQ-001 The module SHALL have parameter IN_WIDTH, default 16, meaning the immediate field width; legal range 8..32.
REQ-002 The module SHALL have parameter OUT_WIDTH, default 32, meaning the extended result width; legal constraint OUT_WIDTH >= IN_WIDTH+2.
REQ-003 The module SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port InValid, input, 1 bit: an input item is offered.
REQ-006 The module SHALL have port InReady, output, 1 bit: the block can accept an item this cycle.
REQ-007 The module SHALL have port Mode, input, 3 bits: the extension mode of the offered item.
REQ-008 The module SHALL have port In, input, IN_WIDTH bits: the immediate value.
REQ-009 The module SHALL have port OutValid, output, 1 bit: Out/Err hold a valid result.
REQ-010 The module SHALL have port OutReady, input, 1 bit: the consumer takes the result this cycle.
REQ-011 The module SHALL have port Out, output, OUT_WIDTH bits: the extended result.
REQ-012 The module SHALL have port Err, output, 1 bit: the result came from a reserved mode.

Function
REQ-013 Transfers SHALL follow these rules: input transfer = InValid & InReady at a clock edge; output transfer = OutValid & OutReady at a clock edge.
REQ-014 Mode 0 (zero-extend) SHALL produce Out = {0, In}.
REQ-015 Mode 1 (sign-extend) SHALL produce Out = In with In[IN_WIDTH-1] replicated into the upper bits.
REQ-016 Mode 2 (upper) SHALL produce Out = In << (OUT_WIDTH-IN_WIDTH), with lower bits 0.
REQ-017 Mode 3 (branch offset) SHALL produce Out = sign-extended In << 2, truncated to OUT_WIDTH.
REQ-018 Mode 4 (byte signed) SHALL produce Out = In[7:0] sign-extended from bit 7.
REQ-019 Mode 5 (byte unsigned) SHALL produce Out = In[7:0] zero-extended.
REQ-020 Modes 6 and 7 (reserved) SHALL produce Out = 0 and Err = 1; Err SHALL be 0 for modes 0-5.
REQ-021 Mode and In SHALL be sampled only on an input transfer; the result SHALL be computed combinationally and stored with the item.
REQ-022 Storage SHALL be a 2-entry skid buffer with states EMPTY, ONE and TWO, and occupancy in {0, 1, 2}.
REQ-023 The state machine SHALL make these transitions:
  - EMPTY -> ONE on push.
  - ONE -> TWO on push without pop.
  - ONE -> EMPTY on pop without push.
  - ONE stays ONE on simultaneous push and pop.
  - TWO -> ONE on pop.
REQ-024 InReady SHALL be a registered output equal to (state != TWO); it SHALL NOT depend combinationally on OutReady.
REQ-025 In state TWO, InValid SHALL be ignored and no item SHALL be lost or overwritten.
REQ-026 OutValid SHALL equal (state != EMPTY).
REQ-027 Out and Err SHALL present the oldest stored item.
REQ-028 Latency SHALL be 1 cycle: an item accepted at edge k appears on Out with OutValid=1 immediately after edge k.
REQ-029 Sustained throughput SHALL be one item per cycle when OutReady=1.
REQ-030 Items SHALL leave in acceptance order.
REQ-031 While OutValid=1 and OutReady=0, Out and Err SHALL remain stable.
REQ-032 A pop in state EMPTY SHALL have no effect.

Reset
REQ-033 When reset=1 at a clock edge, the block SHALL enter EMPTY, drive OutValid=0, InReady=1, Out=0 and Err=0, and discard all stored items, regardless of state or handshakes in the same cycle.
REQ-034 Reset SHALL take priority over simultaneous push or pop.

Verification
REQ-035 Reset sequence: hold reset 2 cycles, then release -> OutValid=0, InReady=1, Out=32'h0, Err=0.
REQ-036 Streaming with OutReady=1:
  - Mode1 In=16'h8001 -> 32'hFFFF8001.
  - Mode0 In=16'h8001 -> 32'h00008001.
  - Mode2 In=16'h1234 -> 32'h12340000.
  - Mode3 In=16'hFFFF -> 32'hFFFFFFFC.
  - Mode4 In=16'h0080 -> 32'hFFFFFF80.
  - Mode5 In=16'h0080 -> 32'h00000080.
  - Each result SHALL appear 1 cycle after acceptance, on back-to-back cycles.
REQ-037 Backpressure: with OutReady=0, offer items A, B, C on consecutive cycles -> A and B accepted, InReady=0 after the second edge, C held off; then raise OutReady -> outputs A, B, C in order with no loss or duplication.
REQ-038 Reserved mode: Mode6 In=16'hABCD -> Out=32'h0, Err=1; a following Mode1 item -> Err=0.
REQ-039 Reset in state TWO, with InValid=1 and OutReady=1 in the same cycle -> after the edge OutValid=0, InReady=1, and no stored item is ever output.
